hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//   Decode-stage hazard detector and the sole source of stallb_en for the stall clock gate.
//   Holds a scoreboard of multi-cycle results in flight (loads, multiplies).
//   Drops stallb_en while the issuing instruction has a RAW or WAW conflict, or while ext_busy is high.
//   Also keeps a saturating stall-cycle counter and a sticky watchdog flag for stalls that never end.
// PARAMETERS
//   NREG     16    number of architectural registers (r0 hardwired zero)
//   RW       4     register address width, log2(NREG)
//   LOAD_LAT 2     cycles until a load result can be forwarded
//   MUL_LAT  4     cycles until a multiply result can be forwarded (1..7)
//   WD_LIM   64    consecutive stall cycles before stall_timeout sets
//   PERF_W   16    width of stall_cycles
// PORTS
//   clk_in         in   1       system clock, posedge active
//   rst            in   1       synchronous reset, active-high
//   issue_valid    in   1       decode holds a valid instruction
//   rs1_addr       in   RW      source 1 register
//   rs1_en         in   1       source 1 is read
//   rs2_addr       in   RW      source 2 register
//   rs2_en         in   1       source 2 is read
//   rd_addr        in   RW      destination register
//   rd_we          in   1       instruction writes rd
//   op_class       in   2       00 single-cycle, 01 load, 10 mul, 11 treated as 00
//   ext_busy       in   1       external multi-cycle unit busy (stall request)
//   flush          in   1       pipeline flush (branch / exception)
//   stallb_en      out  1       1 = run, 0 = stall; to the stall clock gate
//   stall_cycles   out  PERF_W  count of stalled cycles, saturating
//   stall_timeout  out  1       sticky: stall lasted WD_LIM consecutive cycles
//   sb_busy        out  NREG    bit r = scoreboard counter r nonzero (debug)
// BEHAVIOUR
//   Reset values
//     All counters cnt[r] = 0; state = RUN; stall_cycles = 0; stall_timeout = 0.
//     sb_busy = 0; stallb_en = 1 while rst = 1.
//   Scoreboard
//     One 3-bit down-counter cnt[r] per register; cnt[0] is always 0.
//     Every cycle, each nonzero cnt decrements by 1.
//   hazard (combinational)
//     Set when issue_valid and any of:
//       - rs1_en and cnt[rs1_addr] != 0
//       - rs2_en and cnt[rs2_addr] != 0
//       - rd_we and cnt[rd_addr] != 0 (WAW)
//     Accesses to r0 never cause a hazard.
//   stallb_en (combinational, Mealy)
//     stallb_en = rst | flush | ~(hazard | ext_busy).
//     The downstream gate samples it on negedge clk_in.
//     It must be glitch-free by the negedge, so it is derived only from registered state and decode-stage inputs.
//   Issue and scoreboard writes
//     Issue accepted = issue_valid & stallb_en & ~flush.
//     On accept with rd_we, rd_addr != 0 and op_class 01 or 10: cnt[rd_addr] <= LOAD_LAT or MUL_LAT.
//     This write has priority over the same-cycle decrement.
//     op_class 00 / 11 never writes the scoreboard; the result is forwarded.
//   Flush
//     All cnt clear to 0 at the edge; any issue in that cycle is ignored.
//     stallb_en = 1 during the flush cycle.
//     Flush has priority over both decrement and write.
//   FSM (state register)
//     RUN -> STALL when stallb_en = 0; consec counter loads 1.
//     STALL -> RUN when stallb_en = 1; consec clears.
//     STALL -> STALL otherwise; consec increments, saturating at WD_LIM.
//     While in STALL, consec reaching WD_LIM sets stall_timeout.
//     stall_timeout stays set until rst; the FSM keeps operating normally.
//   stall_cycles
//     Increments on every posedge where stallb_en = 0 and rst = 0.
//     Holds at 2^PERF_W - 1 once reached.
//   Reset mid-operation
//     Scoreboard, FSM and counters clear at the next edge.
//     In-flight results are forgotten.
// TESTING
//   Load-use: load r3 accepted at cycle 0; next instr reads r3 (rs1).
//     -> stallb_en = 0 in cycles 1..2, 1 in cycle 3; stall_cycles = 2.
//   Mul WAW then RAW: mul r5 accepted; next instr writes r5 with op 00.
//     -> 4 stall cycles, then accept; sb_busy[5] = 0 afterwards.
//   r0 and op 00: load r0, then read r0; ALU r2 then read r2.
//     -> stallb_en stays 1 throughout; sb_busy = 0.
//   Flush during stall: mul r7, dependent reader, flush in stall cycle 2.
//     -> stallb_en = 1 that cycle; all cnt = 0 next cycle; reader then issues with no stall.
//   Watchdog: hold ext_busy = 1 for 70 cycles.
//     -> stall_timeout rises after cycle 64 and stays 1 after ext_busy drops; stall_cycles = 70.
//   Reset mid-stall: load r4 plus reader, assert rst for 1 cycle during the stall.
//     -> all outputs at reset values; the reader issues immediately after.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard detector: per-register scoreboard of in-flight multi-cycle results,
// stall enable for the stall clock gate, stall-cycle counter and sticky stall watchdog.
module hazard_stall_ctrl #(
  parameter int NREG     = 16,
  parameter int RW       = 4,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int WD_LIM   = 64,
  parameter int PERF_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [RW-1:0]     rs1_addr,
  input  logic              rs1_en,
  input  logic [RW-1:0]     rs2_addr,
  input  logic              rs2_en,
  input  logic [RW-1:0]     rd_addr,
  input  logic              rd_we,
  input  logic [1:0]        op_class,
  input  logic              ext_busy,
  input  logic              flush,
  output logic              stallb_en,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              stall_timeout,
  output logic [NREG-1:0]   sb_busy
);

  // state | meaning
  // RUN   | pipeline advancing, no stall in progress
  // STALL | stallb_en was low at the last edge; consec counts the run of stalled cycles
  typedef enum logic {RUN, STALL} state_t;

  localparam int CW = $clog2(WD_LIM + 1);

  logic [2:0]    cnt [NREG];
  logic          hazard;
  logic          accept;
  logic          sb_write;
  logic [2:0]    sb_lat;
  state_t        state, state_nxt;
  logic [CW-1:0] consec, consec_nxt;
  logic          tmo_set;

  always_comb begin
    hazard = 1'b0;
    if (issue_valid) begin
      if (rs1_en && rs1_addr != '0 && cnt[rs1_addr] != 3'd0) hazard = 1'b1;
      if (rs2_en && rs2_addr != '0 && cnt[rs2_addr] != 3'd0) hazard = 1'b1;
      if (rd_we  && rd_addr  != '0 && cnt[rd_addr]  != 3'd0) hazard = 1'b1;
    end
  end

  // Only registered state and decode inputs feed this, so it settles well before the gate's negedge sample.
  assign stallb_en = rst | flush | ~(hazard | ext_busy);
  assign accept    = issue_valid & stallb_en & ~flush;
  assign sb_write  = accept & rd_we & (rd_addr != '0) & (op_class == 2'b01 || op_class == 2'b10);
  assign sb_lat    = (op_class == 2'b01) ? 3'(LOAD_LAT) : 3'(MUL_LAT);

  always_ff @(posedge clk_in) begin
    cnt[0] <= 3'd0;
    for (int r = 1; r < NREG; r++) begin
      if (rst || flush) begin
        cnt[r] <= 3'd0;
      end else if (sb_write && rd_addr == RW'(r)) begin
        cnt[r] <= sb_lat;
      end else if (cnt[r] != 3'd0) begin
        cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      sb_busy[r] = (cnt[r] != 3'd0);
    end
  end

  always_comb begin
    state_nxt  = state;
    consec_nxt = consec;
    tmo_set    = 1'b0;
    case (state)
      RUN: begin
        if (!stallb_en) begin
          state_nxt  = STALL;
          consec_nxt = CW'(1);
        end
      end
      STALL: begin
        if (stallb_en) begin
          state_nxt  = RUN;
          consec_nxt = '0;
        end else if (consec != CW'(WD_LIM)) begin
          consec_nxt = consec + CW'(1);
        end
      end
      default: begin
        state_nxt  = RUN;
        consec_nxt = '0;
      end
    endcase
    if (state_nxt == STALL && consec_nxt == CW'(WD_LIM)) tmo_set = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= RUN;
      consec        <= '0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      state  <= state_nxt;
      consec <= consec_nxt;
      if (tmo_set) stall_timeout <= 1'b1;
      if (!stallb_en && stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
